dtpu_csr_axil_responder: RTL and testbench

//  CSR responder and PS-side ap_ctrl handshake endpoint of the DTPU. Accepts AXI4-Lite reads and writes from the
//  PS into the CSR file. Serves single-cycle-latency reads from the control unit's CSR port. Drives cs_start,
//  cs_continue and glb_enable to the control unit, and captures its cs_ready, cs_done and cs_idle as PS-visible status.

---
 rtl/dtpu_csr_axil_responder.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dtpu_csr_axil_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtpu_csr_axil_responder.sv
// dtpu_csr_axil_responder: PS-side AXI4-Lite CSR responder and ap_ctrl handshake endpoint of the DTPU.
// Optional feature macro: DTPU_CSR_IRQ_EN adds the irq output plus IER (0x10) and ISR (0x14, W1C).
// Ports:
//   clk, reset (synchronous, active-low)
//   s_axi_aw*/w*/b*/ar*/r*    AXI4-Lite slave; only byte lane 0 carries register data
//   csr_ce/csr_we/csr_address  control-unit read port (writes ignored); csr_dout registered read data
//   csr_reset                  clears ARITH and WINDOW
//   cs_start/cs_continue/glb_enable  controls to the control unit
//   cs_ready/cs_done/cs_idle/cu_state  control-unit status inputs
//   irq (DTPU_CSR_IRQ_EN only) registered interrupt request
module dtpu_csr_axil_responder #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH_CSR     = 8,
  parameter int unsigned ADDRESS_SIZE_CSR   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [1:0]                      s_axi_bresp,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  input  logic                            csr_ce,
  input  logic                            csr_we,
  input  logic [ADDRESS_SIZE_CSR-1:0]     csr_address,
  input  logic                            csr_reset,
  output logic [DATA_WIDTH_CSR-1:0]       csr_dout,
  output logic                            cs_start,
  output logic                            cs_continue,
  output logic                            glb_enable,
`ifdef DTPU_CSR_IRQ_EN
  output logic                            irq,
`endif
  input  logic                            cs_ready,
  input  logic                            cs_done,
  input  logic                            cs_idle,
  input  logic [3:0]                      cu_state
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH_CSR;

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_ARITH  = AW'(4);
  localparam logic [AW-1:0] A_WINDOW = AW'(8);
  localparam logic [AW-1:0] A_STATUS = AW'(12);
`ifdef DTPU_CSR_IRQ_EN
  localparam logic [AW-1:0] A_IER    = AW'(16);
  localparam logic [AW-1:0] A_ISR    = AW'(20);
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t       wstate;
  rstate_t       rstate;
  logic          aw_got, w_got, w_strb_q;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic          ap_done, ap_ready, run_pending;
  logic [DW-1:0] arith, window;
`ifdef DTPU_CSR_IRQ_EN
  logic [1:0]    ier, isr;
`endif

  // Register read mux shared by the AXI and control-unit ports; unmapped reads 0.
  function automatic logic [DW-1:0] reg_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    case (a)
      A_CTRL:   v = DW'({glb_enable, ap_ready, cs_idle, ap_done, cs_start});
      A_ARITH:  v = arith;
      A_WINDOW: v = window;
      A_STATUS: v = DW'(cu_state);
`ifdef DTPU_CSR_IRQ_EN
      A_IER:    v = DW'(ier);
      A_ISR:    v = DW'(isr);
`endif
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic is_mapped(input logic [AW-1:0] a);
    logic m;
    m = (a == A_CTRL) || (a == A_ARITH) || (a == A_WINDOW) || (a == A_STATUS);
`ifdef DTPU_CSR_IRQ_EN
    m = m || (a == A_IER) || (a == A_ISR);
`endif
    return m;
  endfunction

  // Write path: merge captured and same-cycle AW/W beats into one commit.
  logic          aw_hs_c, w_hs_c, have_aw_c, have_w_c, wr_commit_c, wr_en_c;
  logic          wr_strb_c, busy_c, wr_busy_err_c;
  logic [AW-1:0] wr_addr_c;
  logic [DW-1:0] wr_data_c;
  logic [1:0]    wr_resp_c;
  logic          ar_hs_c, rd_ctrl_c;

  always_comb begin
    aw_hs_c       = s_axi_awvalid && s_axi_awready;
    w_hs_c        = s_axi_wvalid && s_axi_wready;
    have_aw_c     = aw_got || aw_hs_c;
    have_w_c      = w_got || w_hs_c;
    wr_commit_c   = (wstate == W_IDLE) && have_aw_c && have_w_c;
    wr_addr_c     = aw_got ? aw_addr_q : s_axi_awaddr;
    wr_data_c     = w_got ? w_data_q : s_axi_wdata[DW-1:0];
    wr_strb_c     = w_got ? w_strb_q : s_axi_wstrb[0];
    busy_c        = cs_start || run_pending;
    wr_busy_err_c = busy_c && ((wr_addr_c == A_ARITH) || (wr_addr_c == A_WINDOW));
    wr_resp_c     = RESP_OKAY;
    if (!is_mapped(wr_addr_c))  wr_resp_c = RESP_DECERR;
    else if (wr_busy_err_c)     wr_resp_c = RESP_SLVERR;
    wr_en_c       = wr_commit_c && wr_strb_c && (wr_resp_c == RESP_OKAY);
    ar_hs_c       = s_axi_arvalid && s_axi_arready;
    rd_ctrl_c     = ar_hs_c && (s_axi_araddr == A_CTRL);
  end

  // Write channel FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs_c) begin
            aw_got    <= 1'b1;
            aw_addr_q <= s_axi_awaddr;
          end
          if (w_hs_c) begin
            w_got    <= 1'b1;
            w_data_q <= s_axi_wdata[DW-1:0];
            w_strb_q <= s_axi_wstrb[0];
          end
          if (wr_commit_c) begin
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_resp_c;
            wstate        <= W_RESP;
          end else begin
            s_axi_awready <= !have_aw_c;
            s_axi_wready  <= !have_w_c;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read channel FSM; data is sampled at the AR handshake and held until rready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (ar_hs_c) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= C_S_AXI_DATA_WIDTH'(reg_read(s_axi_araddr));
            s_axi_rresp   <= is_mapped(s_axi_araddr) ? RESP_OKAY : RESP_DECERR;
            rstate        <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Register file, start/continue handshake and control-unit read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_start    <= 1'b0;
      cs_continue <= 1'b0;
      glb_enable  <= 1'b0;
      run_pending <= 1'b0;
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      arith       <= '0;
      window      <= '0;
      csr_dout    <= '0;
`ifdef DTPU_CSR_IRQ_EN
      ier         <= '0;
      isr         <= '0;
      irq         <= 1'b0;
`endif
    end else begin
      cs_continue <= 1'b0;
      if (cs_start && cs_ready) cs_start <= 1'b0;
      if (cs_done) run_pending <= 1'b0;
      // Set events are ordered after clear-on-read so they win.
      if (rd_ctrl_c) begin
        ap_done  <= 1'b0;
        ap_ready <= 1'b0;
      end
      if (cs_done)  ap_done  <= 1'b1;
      if (cs_ready) ap_ready <= 1'b1;
      if (csr_ce) csr_dout <= reg_read(AW'(csr_address[3:0]));
      if (wr_en_c) begin
        case (wr_addr_c)
          A_CTRL: begin
            glb_enable  <= wr_data_c[4];
            cs_continue <= wr_data_c[5];
            if (wr_data_c[0] && !cs_start) begin
              cs_start    <= 1'b1;
              run_pending <= 1'b1;
            end
          end
          A_ARITH:  arith  <= wr_data_c;
          A_WINDOW: window <= wr_data_c;
`ifdef DTPU_CSR_IRQ_EN
          A_IER:    ier <= wr_data_c[1:0];
          A_ISR:    isr <= isr & ~wr_data_c[1:0];
`endif
          default: ;
        endcase
      end
      if (csr_reset) begin
        arith  <= '0;
        window <= '0;
      end
`ifdef DTPU_CSR_IRQ_EN
      if (cs_done)  isr[0] <= 1'b1;
      if (cs_ready) isr[1] <= 1'b1;
      irq <= |(ier & isr);
`endif
    end
  end

  logic unused_c;
  assign unused_c = ^{csr_we, csr_address[ADDRESS_SIZE_CSR-1:4],
                      s_axi_wdata[C_S_AXI_DATA_WIDTH-1:DW], s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_dtpu_csr_axil_responder.sv
// Directed self-checking bench for dtpu_csr_axil_responder.
module tb_dtpu_csr_axil_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_awvalid, s_axi_awready;
  logic [5:0]  s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [5:0]  s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        csr_ce, csr_we, csr_reset;
  logic [31:0] csr_address;
  logic [7:0]  csr_dout;
  logic        cs_start, cs_continue, glb_enable;
  logic        cs_ready, cs_done, cs_idle;
  logic [3:0]  cu_state;
`ifdef DTPU_CSR_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;
  int cont_cnt = 0;

  always #5 clk = ~clk;

  dtpu_csr_axil_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .csr_ce(csr_ce), .csr_we(csr_we), .csr_address(csr_address), .csr_reset(csr_reset),
    .csr_dout(csr_dout), .cs_start(cs_start), .cs_continue(cs_continue), .glb_enable(glb_enable),
`ifdef DTPU_CSR_IRQ_EN
    .irq(irq),
`endif
    .cs_ready(cs_ready), .cs_done(cs_done), .cs_idle(cs_idle), .cu_state(cu_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (cs_continue) cont_cnt++;
  endtask

  task automatic pulse(input int which);
    if (which == 0) cs_ready = 1'b1; else cs_done = 1'b1;
    step();
    cs_ready = 1'b0;
    cs_done  = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [7:0] data, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = {24'h0, data};
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      step();
      n++;
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      step();
      n++;
    end
    check("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      step();
      n++;
    end
    step();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      step();
      n++;
    end
    repeat (hold) step();
    check("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
  endtask

  task automatic cu_read(input logic [31:0] addr);
    csr_ce      = 1'b1;
    csr_address = addr;
    step();
    csr_ce = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    reset = 1'b0;
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_rready = 0;
    csr_ce = 0; csr_we = 0; csr_address = 0; csr_reset = 0;
    cs_ready = 0; cs_done = 0; cs_idle = 1; cu_state = 4'h0;
    repeat (3) step();
    check("reset_outputs", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                                s_axi_rvalid, s_axi_rresp, csr_dout, cs_start, cs_continue, glb_enable}), 32'd0);
    check("reset_rdata", s_axi_rdata, 32'd0);
    reset = 1'b1;
    repeat (2) step();

    // Idle CTRL read, with rready held off for 3 cycles.
    axi_read(6'h00, 3, d, r);
    check("t1_ctrl_rdata", d, 32'h04);
    check("t1_ctrl_rresp", 32'(r), 32'd0);

    // ARITH write and CU read; CU sees the old value on a same-cycle write.
    axi_write(6'h04, 8'h0A, r);
    check("t2_wr_bresp", 32'(r), 32'd0);
    cu_read(32'h4);
    check("t2_cu_arith", 32'(csr_dout), 32'h0A);
    s_axi_awaddr = 6'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0B; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    check("t2_ready_pre", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    cu_read(32'h4);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("t2_cu_old", 32'(csr_dout), 32'h0A);
    check("t2_bvalid", 32'(s_axi_bvalid), 32'd1);
    s_axi_bready = 1'b1; step(); s_axi_bready = 1'b0;
    repeat (2) step();
    check("t2_cu_hold", 32'(csr_dout), 32'h0A);
    cu_read(32'h4);
    check("t2_cu_new", 32'(csr_dout), 32'h0B);

    // Start handshake and sticky ap_ready.
    axi_write(6'h00, 8'h11, r);
    check("t3_start_en", 32'({glb_enable, cs_start}), 32'h3);
    repeat (5) step();
    check("t3_start_held", 32'(cs_start), 32'd1);
    pulse(0);
    check("t3_start_clr", 32'(cs_start), 32'd0);
    axi_read(6'h00, 0, d, r);
    check("t3_ctrl_ready", d, 32'h1C);
    axi_read(6'h00, 0, d, r);
    check("t3_ctrl_cor", d, 32'h14);

    // Busy protection of WINDOW until cs_done.
    axi_write(6'h00, 8'h11, r);
    check("t4_restart", 32'(cs_start), 32'd1);
    axi_write(6'h08, 8'h33, r);
    check("t4_busy_bresp", 32'(r), 32'h2);
    axi_read(6'h08, 0, d, r);
    check("t4_window_kept", d, 32'h0);
    pulse(0);
    axi_write(6'h08, 8'h33, r);
    check("t4_pending_bresp", 32'(r), 32'h2);
    pulse(1);
    axi_write(6'h08, 8'h33, r);
    check("t4_ok_bresp", 32'(r), 32'h0);
    axi_read(6'h08, 0, d, r);
    check("t4_window", d, 32'h33);
    axi_read(6'h00, 0, d, r);
    check("t4_ctrl_done", d, 32'h1E);

    // W leads AW by 3 cycles, bready held low 4 cycles; one continue pulse.
    cont_cnt = 0;
    s_axi_wdata = 32'h30; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    check("t5_wready", 32'(s_axi_wready), 32'd1);
    step();
    s_axi_wvalid = 1'b0;
    check("t5_wready_drop", 32'(s_axi_wready), 32'd0);
    step(); step();
    check("t5_no_early_b", 32'(s_axi_bvalid), 32'd0);
    s_axi_awaddr = 6'h00; s_axi_awvalid = 1'b1;
    check("t5_awready", 32'(s_axi_awready), 32'd1);
    step();
    s_axi_awvalid = 1'b0;
    check("t5_bvalid", 32'(s_axi_bvalid), 32'd1);
    repeat (4) step();
    check("t5_b_held", 32'({s_axi_bvalid, s_axi_bresp}), 32'h4);
    s_axi_bready = 1'b1; step(); s_axi_bready = 1'b0;
    check("t5_b_done", 32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'h3);
    check("t5_cont_once", 32'(cont_cnt), 32'd1);
    check("t5_glb", 32'(glb_enable), 32'd1);
    axi_write(6'h3C, 8'h55, r);
    check("t5_decerr_w", 32'(r), 32'h3);
    axi_read(6'h3C, 0, d, r);
    check("t5_decerr_r", {d[29:0], r}, 32'h3);
`ifndef DTPU_CSR_IRQ_EN
    axi_write(6'h10, 8'h01, r);
    check("t5_ier_unmapped", 32'(r), 32'h3);
`endif

    // CU status, unmapped CU read, csr_reset.
    cu_state = 4'hA;
    cu_read(32'hC);
    check("t6_status", 32'(csr_dout), 32'h0A);
    cu_read(32'h2);
    check("t6_cu_unmapped", 32'(csr_dout), 32'h0);
    csr_reset = 1'b1; step(); csr_reset = 1'b0;
    axi_read(6'h04, 0, d, r);
    check("t6_arith_clr", d, 32'h0);
    axi_read(6'h08, 0, d, r);
    check("t6_window_clr", d, 32'h0);
    cu_read(32'h0);
    check("t6_ctrl_kept", 32'(csr_dout), 32'h14);

    // cs_done coinciding with the clear-on-read handshake keeps ap_done set.
    s_axi_araddr = 6'h00; s_axi_arvalid = 1'b1;
    check("t7_arready", 32'(s_axi_arready), 32'd1);
    cs_done = 1'b1;
    step();
    cs_done = 1'b0; s_axi_arvalid = 1'b0;
    check("t7_rd_pre", s_axi_rdata, 32'h14);
    s_axi_rready = 1'b1; step(); s_axi_rready = 1'b0;
    axi_read(6'h00, 0, d, r);
    check("t7_done_wins", d, 32'h16);

`ifdef DTPU_CSR_IRQ_EN
    axi_write(6'h10, 8'h01, r);
    pulse(1);
    step();
    check("t8_irq_set", 32'(irq), 32'd1);
    axi_write(6'h14, 8'h01, r);
    step();
    check("t8_irq_clr", 32'(irq), 32'd0);
`endif

    // Reset with a response pending: no response survives.
    s_axi_awaddr = 6'h08; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("t9_b_pending", 32'(s_axi_bvalid), 32'd1);
    reset = 1'b0;
    step();
    check("t9_abort", 32'({s_axi_bvalid, s_axi_awready, glb_enable, cs_start}), 32'd0);
    reset = 1'b1;
    repeat (2) step();
    axi_read(6'h08, 0, d, r);
    check("t9_window_reset", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
